// File: rtl/pedestrian_drawer.sv
// rtl/pedestrian_drawer.sv - erase/move/draw sequencer for the pedestrian sprite
module pedestrian_drawer #(
  parameter int         SPRITE_W   = 4,
  parameter int         SPRITE_H   = 4,
  parameter logic [2:0] PED_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter int         Y_LIMIT    = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] ped_x,
  input  logic [7:0] ped_y,
  input  logic       dead,
  output logic       can_move,
  output logic       plot,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] colour,
  output logic       busy,
  output logic [3:0] deaths
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ERASE  = 3'd1;
  localparam logic [2:0] MOVE   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DRAW   = 3'd4;

  localparam logic [2:0] COL_LAST = 3'(SPRITE_W - 1);
  localparam logic [2:0] ROW_LAST = 3'(SPRITE_H - 1);
  localparam logic [9:0] Y_LIM    = 10'(Y_LIMIT);

  logic [2:0] state;
  logic [2:0] col;
  logic [2:0] row;
  logic [7:0] old_x;
  logic [7:0] old_y;
  logic [7:0] draw_x;
  logic [7:0] draw_y;
  logic       old_valid;

  logic       pixel_phase;
  logic       last_pixel;
  logic [7:0] base_x;
  logic [7:0] base_y;
  logic [8:0] sum_x;
  logic [8:0] sum_y;

  assign pixel_phase = (state == ERASE) || (state == DRAW);
  assign last_pixel  = (col == COL_LAST) && (row == ROW_LAST);

  // ERASE repaints where the sprite was last drawn; DRAW uses the position sampled in SETTLE
  assign base_x = (state == DRAW) ? draw_x : old_x;
  assign base_y = (state == DRAW) ? draw_y : old_y;
  assign sum_x  = {1'b0, base_x} + {6'd0, col};
  assign sum_y  = {1'b0, base_y} + {6'd0, row};

  assign plot     = pixel_phase && ({1'b0, sum_y} < Y_LIM);
  assign vga_x    = pixel_phase ? sum_x : 9'd0;
  assign vga_y    = pixel_phase ? sum_y[7:0] : 8'd0;
  assign colour   = (state == DRAW) ? PED_COLOUR : ((state == ERASE) ? BG_COLOUR : 3'd0);
  assign can_move = (state == MOVE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= 3'd0;
      row       <= 3'd0;
      old_x     <= 8'd0;
      old_y     <= 8'd0;
      draw_x    <= 8'd0;
      draw_y    <= 8'd0;
      old_valid <= 1'b0;
      deaths    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          col <= 3'd0;
          row <= 3'd0;
          if (frame_tick) state <= old_valid ? ERASE : MOVE;
        end
        ERASE, DRAW: begin
          if (last_pixel) begin
            col <= 3'd0;
            row <= 3'd0;
            if (state == ERASE) begin
              state <= MOVE;
            end else begin
              state     <= IDLE;
              old_x     <= draw_x;
              old_y     <= draw_y;
              old_valid <= 1'b1;
            end
          end else if (col == COL_LAST) begin
            col <= 3'd0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        MOVE: state <= SETTLE;
        SETTLE: begin
          // upstream has registered its new position by now
          draw_x <= ped_x;
          draw_y <= ped_y;
          if (dead && (deaths != 4'hF)) deaths <= deaths + 4'd1;
          state <= DRAW;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
